// File: rtl/reg_file_mp_pkg.sv
// Shared constants and port-packing helper for the multi-port register file.
// Decode and the register file agree on how packed read ports are sliced.
package reg_file_mp_pkg;

    localparam int DEF_DATA_W   = 32;
    localparam int DEF_ADDR_W   = 5;
    localparam int DEF_NUM_RD   = 2;
    localparam int DEF_ZERO_REG = 1;
    localparam int DEF_DEPTH    = 2 ** DEF_ADDR_W;

    // Port k of a packed bus of w-bit fields starts at bit k*w.
    function automatic int port_lo(input int k, input int w);
        return k * w;
    endfunction

endpackage

// File: rtl/reg_scoreboard.sv
// Per-register busy bits for the hazard unit: a reserve at issue sets the bit
// and a writeback clears it. Each read port also gets a busy lookup.
module reg_scoreboard
    import reg_file_mp_pkg::*;
#(
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int NUM_RD   = DEF_NUM_RD,
    parameter int ZERO_REG = DEF_ZERO_REG
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       write_enable,
    input  logic [ADDR_W-1:0]          write_reg,
    input  logic                       reserve_en,
    input  logic [ADDR_W-1:0]          reserve_reg,
    input  logic [NUM_RD*ADDR_W-1:0]   read_reg,
    output logic [(1<<ADDR_W)-1:0]     busy_vec,
    output logic [NUM_RD-1:0]          read_busy
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DEPTH-1:0]  busy_r;
    logic [DEPTH-1:0]  busy_nxt_s;
    logic [ADDR_W-1:0] rd_addr_s [NUM_RD];

    // Next busy state: a reserve outranks a same-register writeback clear.
    always_comb begin
        busy_nxt_s = busy_r;
        for (int i = 0; i < DEPTH; i++) begin
            if ((ZERO_REG != 0) && (i == 0)) begin
                busy_nxt_s[i] = 1'b0;
            end else if (reserve_en && (reserve_reg == ADDR_W'(i))) begin
                busy_nxt_s[i] = 1'b1;
            end else if (write_enable && (write_reg == ADDR_W'(i))) begin
                busy_nxt_s[i] = 1'b0;
            end else begin
                busy_nxt_s[i] = busy_r[i];
            end
        end
    end

    // Busy-bit storage.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_r <= {DEPTH{1'b0}};
        end else begin
            busy_r <= busy_nxt_s;
        end
    end

    // Per-port lookup; an in-flight writeback to the same register is served by the bypass.
    always_comb begin
        read_busy = {NUM_RD{1'b0}};
        for (int k = 0; k < NUM_RD; k++) begin
            rd_addr_s[k] = read_reg[port_lo(k, ADDR_W) +: ADDR_W];
            if ((ZERO_REG != 0) && (rd_addr_s[k] == {ADDR_W{1'b0}})) begin
                read_busy[k] = 1'b0;
            end else begin
                read_busy[k] = busy_r[rd_addr_s[k]] &&
                               !(write_enable && (write_reg == rd_addr_s[k]));
            end
        end
    end

    assign busy_vec = busy_r;

endmodule

// File: rtl/reg_file_mp.sv
// Parametrised multi-read-port register file with writeback bypass and a
// busy scoreboard; sits between decode (read/reserve) and writeback (write).
module reg_file_mp
    import reg_file_mp_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int NUM_RD   = DEF_NUM_RD,
    parameter int ZERO_REG = DEF_ZERO_REG
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       write_enable,
    input  logic [ADDR_W-1:0]          write_reg,
    input  logic [DATA_W-1:0]          write_data,
    input  logic [NUM_RD*ADDR_W-1:0]   read_reg,
    output logic [NUM_RD*DATA_W-1:0]   read_data,
    output logic [NUM_RD-1:0]          read_busy,
    input  logic                       reserve_en,
    input  logic [ADDR_W-1:0]          reserve_reg,
    output logic [(1<<ADDR_W)-1:0]     busy_vec
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] regs_r [DEPTH];
    logic [ADDR_W-1:0] rd_addr_s [NUM_RD];
    logic              wr_commit_s;

    assign wr_commit_s = write_enable &&
                         !((ZERO_REG != 0) && (write_reg == {ADDR_W{1'b0}}));

    // Register storage; reset clears every entry so no read is ever X.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_r[i] <= {DATA_W{1'b0}};
            end
        end else if (wr_commit_s) begin
            regs_r[write_reg] <= write_data;
        end
    end

    // Combinational read ports; the writeback value bypasses the array in its own cycle.
    always_comb begin
        read_data = {(NUM_RD*DATA_W){1'b0}};
        for (int k = 0; k < NUM_RD; k++) begin
            rd_addr_s[k] = read_reg[port_lo(k, ADDR_W) +: ADDR_W];
            if (rst) begin
                read_data[port_lo(k, DATA_W) +: DATA_W] = {DATA_W{1'b0}};
            end else if ((ZERO_REG != 0) && (rd_addr_s[k] == {ADDR_W{1'b0}})) begin
                read_data[port_lo(k, DATA_W) +: DATA_W] = {DATA_W{1'b0}};
            end else if (write_enable && (write_reg == rd_addr_s[k])) begin
                read_data[port_lo(k, DATA_W) +: DATA_W] = write_data;
            end else begin
                read_data[port_lo(k, DATA_W) +: DATA_W] = regs_r[rd_addr_s[k]];
            end
        end
    end

    reg_scoreboard #(
        .ADDR_W   (ADDR_W),
        .NUM_RD   (NUM_RD),
        .ZERO_REG (ZERO_REG)
    ) u_scoreboard (
        .clk          (clk),
        .rst          (rst),
        .write_enable (write_enable),
        .write_reg    (write_reg),
        .reserve_en   (reserve_en),
        .reserve_reg  (reserve_reg),
        .read_reg     (read_reg),
        .busy_vec     (busy_vec),
        .read_busy    (read_busy)
    );

endmodule

// File: tb/tb_reg_file_mp.sv
// Self-checking bench: default configuration and a 64-bit/16-entry/3-port
// configuration without a zero register, against an array-based reference.
module tb_reg_file_mp;
    import reg_file_mp_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // default configuration: 32 x 32, 2 ports, zero register
    logic        we0, res0;
    logic [4:0]  wr0, rsv0;
    logic [31:0] wd0;
    logic [9:0]  rr0;
    logic [63:0] rd0;
    logic [1:0]  rb0;
    logic [DEF_DEPTH-1:0] bv0;

    // swept configuration: 16 x 64, 3 ports, ordinary r0
    logic         we1, res1;
    logic [3:0]   wr1, rsv1;
    logic [63:0]  wd1;
    logic [11:0]  rr1;
    logic [191:0] rd1;
    logic [2:0]   rb1;
    logic [15:0]  bv1;

    reg_file_mp dut0 (
        .clk(clk), .rst(rst), .write_enable(we0), .write_reg(wr0), .write_data(wd0),
        .read_reg(rr0), .read_data(rd0), .read_busy(rb0),
        .reserve_en(res0), .reserve_reg(rsv0), .busy_vec(bv0)
    );

    reg_file_mp #(.DATA_W(64), .ADDR_W(4), .NUM_RD(3), .ZERO_REG(0)) dut1 (
        .clk(clk), .rst(rst), .write_enable(we1), .write_reg(wr1), .write_data(wd1),
        .read_reg(rr1), .read_data(rd1), .read_busy(rb1),
        .reserve_en(res1), .reserve_reg(rsv1), .busy_vec(bv1)
    );

    int n_vec = 0;
    int n_err = 0;

    // reference state
    logic [31:0] m0 [32];
    bit          b0 [32];
    logic [63:0] m1 [16];
    bit          b1 [16];

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] exp_rd0(input logic [4:0] a);
        if (rst || a == 5'd0) return 32'd0;
        if (we0 && wr0 == a) return wd0;
        return m0[a];
    endfunction

    function automatic logic exp_rb0(input logic [4:0] a);
        if (rst || a == 5'd0) return 1'b0;
        return b0[a] && !(we0 && wr0 == a);
    endfunction

    function automatic logic [63:0] exp_rd1(input logic [3:0] a);
        if (rst) return 64'd0;
        if (we1 && wr1 == a) return wd1;
        return m1[a];
    endfunction

    function automatic logic exp_rb1(input logic [3:0] a);
        if (rst) return 1'b0;
        return b1[a] && !(we1 && wr1 == a);
    endfunction

    task automatic clear_model();
        for (int i = 0; i < 32; i++) begin m0[i] = 32'd0; b0[i] = 1'b0; end
        for (int i = 0; i < 16; i++) begin m1[i] = 64'd0; b1[i] = 1'b0; end
    endtask

    task automatic check_all();
        logic [31:0] ev0;
        logic [15:0] ev1;
        for (int k = 0; k < 2; k++) begin
            check_eq("rd0", {32'd0, rd0[k*32 +: 32]}, {32'd0, exp_rd0(rr0[k*5 +: 5])});
            check_eq("rb0", 64'(rb0[k]), 64'(exp_rb0(rr0[k*5 +: 5])));
        end
        for (int i = 0; i < 32; i++) ev0[i] = b0[i];
        check_eq("bv0", 64'(bv0), 64'(ev0));
        for (int k = 0; k < 3; k++) begin
            check_eq("rd1", rd1[k*64 +: 64], exp_rd1(rr1[k*4 +: 4]));
            check_eq("rb1", 64'(rb1[k]), 64'(exp_rb1(rr1[k*4 +: 4])));
        end
        for (int i = 0; i < 16; i++) ev1[i] = b1[i];
        check_eq("bv1", 64'(bv1), 64'(ev1));
    endtask

    // Architectural effect of one clock edge with the current inputs.
    task automatic update_model();
        if (rst) begin
            clear_model();
        end else begin
            if (we0 && wr0 != 5'd0) m0[wr0] = wd0;
            if (we0) b0[wr0] = 1'b0;
            if (res0 && rsv0 != 5'd0) b0[rsv0] = 1'b1;
            if (we1) m1[wr1] = wd1;
            if (we1) b1[wr1] = 1'b0;
            if (res1) b1[rsv1] = 1'b1;
        end
    endtask

    task automatic tick();
        if (rst) clear_model();
        #1 check_all();
        @(posedge clk);
        update_model();
        #1;
    endtask

    function automatic logic [4:0] pick0();
        if ($urandom_range(0, 3) == 0) return 5'($urandom_range(0, 31));
        return 5'($urandom_range(0, 7));
    endfunction

    initial begin
        rst = 1'b1;
        we0 = 1'b0; wr0 = 5'd0; wd0 = 32'd0; rr0 = 10'd0; res0 = 1'b0; rsv0 = 5'd0;
        we1 = 1'b0; wr1 = 4'd0; wd1 = 64'd0; rr1 = 12'd0; res1 = 1'b0; rsv1 = 4'd0;
        clear_model();
        tick();
        check_eq("reset_bv0", 64'(bv0), 64'd0);
        rst = 1'b0;
        tick();

        // preload r5 and reserve it, then reset mid-cycle
        we0 = 1'b1; wr0 = 5'd5; wd0 = 32'hDEADBEEF; res0 = 1'b1; rsv0 = 5'd5;
        tick();
        we0 = 1'b0; res0 = 1'b0; rr0 = {5'd0, 5'd5};
        #1 check_eq("pre_rst_r5", {32'd0, rd0[31:0]}, 64'hDEADBEEF);
        check_eq("pre_rst_busy5", 64'(bv0[5]), 64'd1);
        #2 rst = 1'b1;
        #1 check_eq("rst_r5", {32'd0, rd0[31:0]}, 64'd0);
        check_eq("rst_bv0", 64'(bv0), 64'd0);
        we0 = 1'b1; wr0 = 5'd5; wd0 = 32'h00001234;
        tick();
        rst = 1'b0; we0 = 1'b0;
        #1 check_eq("rst_discard", {32'd0, rd0[31:0]}, 64'd0);
        tick();

        // write r7 then read r7/r0; write to r0 is ignored
        we0 = 1'b1; wr0 = 5'd7; wd0 = 32'h12345678;
        tick();
        we0 = 1'b1; wr0 = 5'd0; wd0 = 32'hFFFFFFFF; rr0 = {5'd0, 5'd7};
        #1 check_eq("r7", {32'd0, rd0[31:0]}, 64'h12345678);
        check_eq("r0_bypass_blocked", {32'd0, rd0[63:32]}, 64'd0);
        tick();
        we0 = 1'b0;
        #1 check_eq("r0_zero", {32'd0, rd0[63:32]}, 64'd0);
        tick();

        // bypass on port 1
        we0 = 1'b1; wr0 = 5'd9; wd0 = 32'hA5A5A5A5; rr0 = {5'd9, 5'd7};
        #1 check_eq("bypass_r9", {32'd0, rd0[63:32]}, 64'hA5A5A5A5);
        tick();
        we0 = 1'b0;

        // scoreboard reserve / clear
        res0 = 1'b1; rsv0 = 5'd3; rr0 = {5'd3, 5'd3};
        tick();
        res0 = 1'b0;
        #1 check_eq("busy3", 64'(bv0[3]), 64'd1);
        check_eq("rb_r3", 64'(rb0), 64'd3);
        we0 = 1'b1; wr0 = 5'd3; wd0 = 32'h33;
        #1 check_eq("rb_r3_wb", 64'(rb0), 64'd0);
        tick();
        we0 = 1'b0;
        #1 check_eq("busy3_clr", 64'(bv0[3]), 64'd0);

        // same-cycle reserve/write on r4; then reserve r4 while writing busy r6
        we0 = 1'b1; wr0 = 5'd4; wd0 = 32'h44; res0 = 1'b1; rsv0 = 5'd4;
        tick();
        we0 = 1'b0; res0 = 1'b1; rsv0 = 5'd6; rr0 = {5'd6, 5'd4};
        #1 check_eq("r4_data", {32'd0, rd0[31:0]}, 64'h44);
        check_eq("busy4_set", 64'(bv0[4]), 64'd1);
        tick();
        we0 = 1'b1; wr0 = 5'd6; wd0 = 32'h66; res0 = 1'b1; rsv0 = 5'd4;
        tick();
        we0 = 1'b0; res0 = 1'b0;
        #1 check_eq("busy4_diff", 64'(bv0[4]), 64'd1);
        check_eq("busy6_diff", 64'(bv0[6]), 64'd0);

        // swept configuration: ordinary r0 and three independent ports
        we1 = 1'b1; wr1 = 4'd0; wd1 = 64'h1_0000_0001;
        tick();
        we1 = 1'b1; wr1 = 4'd1; wd1 = 64'hAAAA_0000_0000_AAAA; res1 = 1'b1; rsv1 = 4'd0;
        tick();
        we1 = 1'b1; wr1 = 4'd2; wd1 = 64'hBBBB_0000_0000_BBBB; res1 = 1'b0;
        tick();
        we1 = 1'b0; rr1 = {4'd2, 4'd1, 4'd0};
        #1 check_eq("w64_r0", rd1[63:0], 64'h1_0000_0001);
        check_eq("w64_r1", rd1[127:64], 64'hAAAA_0000_0000_AAAA);
        check_eq("w64_r2", rd1[191:128], 64'hBBBB_0000_0000_BBBB);
        check_eq("w64_busy0", 64'(rb1), 64'd1);
        tick();

        // randomized traffic
        for (int n = 0; n < 1500; n++) begin
            rst  = ($urandom_range(0, 199) == 0);
            we0  = 1'($urandom_range(0, 1));
            wr0  = pick0();
            wd0  = $urandom;
            res0 = 1'($urandom_range(0, 1));
            rsv0 = pick0();
            rr0  = {pick0(), pick0()};
            we1  = 1'($urandom_range(0, 1));
            wr1  = 4'($urandom_range(0, 15));
            wd1  = {$urandom, $urandom};
            res1 = 1'($urandom_range(0, 1));
            rsv1 = 4'($urandom_range(0, 15));
            rr1  = 12'($urandom_range(0, 4095));
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/reg_file_mp.md
Name: reg_file_mp

Overview:
- Parametrised successor of the 32x32 CPU register file: configurable width, depth and read-port count.
- Adds asynchronous reset of all state, write-to-read bypass, and a per-register busy scoreboard for the pipeline hazard unit.
- Sits between decode (read/reserve) and writeback (write) in the pipelined datapath.

Parameters:
- DATA_W, 32, register width in bits.
- ADDR_W, 5, address width; depth = 2**ADDR_W.
- NUM_RD, 2, number of read ports (1..4).
- ZERO_REG, 1, 1 = register 0 reads as zero, ignores writes and is never busy; 0 = register 0 is an ordinary register.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- write_enable  in  1  commit wdata to write_reg this edge
- write_reg  in  ADDR_W  write address
- write_data  in  DATA_W  write data
- read_reg  in  NUM_RD*ADDR_W  packed read addresses; port k uses bits [k*ADDR_W +: ADDR_W]
- read_data  out  NUM_RD*DATA_W  packed read data, same packing
- read_busy  out  NUM_RD  port k's register has a pending producer
- reserve_en  in  1  mark reserve_reg busy (instruction issued)
- reserve_reg  in  ADDR_W  register to reserve
- busy_vec  out  2**ADDR_W  raw scoreboard bits, for debug and hazard unit

Behaviour:
- Reset: on rst high, asynchronously and immediately, all registers = 0 and all busy bits = 0. Outputs follow combinationally, so read_data = 0 and read_busy = 0. Reset asserted mid-write discards the write.
- Write: on a rising clk edge with write_enable=1 (and write_reg!=0 when ZERO_REG=1), registers[write_reg] <= write_data.
- Read path is combinational, with zero latency from read_reg.
  - If ZERO_REG=1 and addr==0: data = 0.
  - Else if write_enable && write_reg==addr: data = write_data (same-cycle bypass).
  - Else: data = registers[addr].
  - Ports are independent; all ports may read the same address.
- Scoreboard: one busy bit per register, updated on the rising edge.
  - reserve_en sets busy[reserve_reg].
  - write_enable clears busy[write_reg].
  - Same register reserved and written in one cycle: busy ends SET, because the newer producer wins. The data write still happens.
  - Different registers: both actions take effect.
  - Reserving an already-busy register leaves it busy; no count is kept (single outstanding producer per register).
  - Writing a non-busy register is legal; busy stays 0.
  - With ZERO_REG=1, busy[0] is held 0 and reserves to register 0 are ignored.
- read_busy[k] = busy[addr_k] && !(write_enable && write_reg==addr_k). The in-flight writeback satisfies the hazard through the bypass. It is forced to 0 for register 0 when ZERO_REG=1.
- No X propagation: every register is defined from reset.

Decomposition:
- Shared package holds:
  - default constants DATA_W, ADDR_W, NUM_RD;
  - a localparam for DEPTH = 2**ADDR_W;
  - the packing helper convention (port k slice offset) used by decode.
- One sub-module, reg_scoreboard: busy-bit array with its set/clear priority, busy_vec and the per-port read_busy lookups. Storage and bypass stay in reg_file_mp.

Test Plan:
- Reset: preload r5=0xDEADBEEF, assert rst mid-cycle → read_data for r5 = 0 immediately (before the next edge), busy_vec = 0.
- Write/read: write r7=0x12345678, then read port0=r7, port1=r0 → 0x12345678 and 0 next cycle. Writing r0=0xFFFF_FFFF leaves r0 reading 0.
- Bypass: write_enable=1, write_reg=9, write_data=0xA5A5A5A5, read_reg port1=9 in the same cycle → read_data port1 = 0xA5A5A5A5 before the edge. The old value of r9 is never visible on that port.
- Scoreboard:
  - Reserve r3 → busy_vec[3]=1 and read_busy=1 on any port reading r3.
  - Write r3 → busy clears after the edge; read_busy=0 during the write cycle.
- Simultaneous events: reserve r4 and write r4 in the same cycle → r4 holds the new data and busy_vec[4]=1. Reserve r4 and write r6 → busy[4]=1 and busy[6]=0.
- Parameter sweep: DATA_W=64, ADDR_W=4, NUM_RD=3, ZERO_REG=0.
  - Write r0=0x1_0000_0001 → reads back 0x1_0000_0001.
  - Reserve r0 → busy.
  - All 3 ports return correct independent addresses.
